// File: rtl/vgpu_fifo_pkg.sv
// Shared sizing defaults and helpers for the vGPU single-clock FIFOs.
package vgpu_fifo_pkg;

  localparam int unsigned FIFO_DATA_SIZE = 32;
  localparam int unsigned FIFO_ADDR_SIZE = 5;

  // Almost-full sits this many words below DEPTH by default.
  localparam int unsigned FIFO_AFULL_MARGIN = 4;
  localparam int unsigned FIFO_AEMPTY_LVL   = 4;

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_SIZE storage: clocked write, asynchronous read, no reset.
module fifo_sync_ram
  import vgpu_fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = FIFO_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = FIFO_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with wrap-bit pointers, threshold flags, sticky error
// flags and a selectable standard / first-word-fall-through read port.
module fifo_sync
  import vgpu_fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = FIFO_DATA_SIZE,
  parameter int unsigned ADDR_SIZE  = FIFO_ADDR_SIZE,
  parameter int unsigned AFULL_LVL  = fifo_depth(ADDR_SIZE) - FIFO_AFULL_MARGIN,
  parameter int unsigned AEMPTY_LVL = FIFO_AEMPTY_LVL,
  parameter int unsigned FWFT       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic                 overflow,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic                 underflow,
  output logic [ADDR_SIZE:0]   count
);

  localparam int unsigned PTR_W = ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] AFULL_CNT  = PTR_W'(AFULL_LVL);
  localparam logic [PTR_W-1:0] AEMPTY_CNT = PTR_W'(AEMPTY_LVL);

  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic                 r_overflow;
  logic                 r_underflow;

  logic [PTR_W-1:0]     w_wptr_nxt;
  logic [PTR_W-1:0]     w_rptr_nxt;
  logic                 w_overflow_nxt;
  logic                 w_underflow_nxt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_ram_we;
  logic [PTR_W-1:0]     w_count;
  logic [DATA_SIZE-1:0] w_ram_rdata;

  // Status is a pure function of the registered pointers.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_SIZE] != r_rptr[ADDR_SIZE]) &&
                   (r_wptr[ADDR_SIZE-1:0] == r_rptr[ADDR_SIZE-1:0]);
  assign w_count = r_wptr - r_rptr;

  assign w_wr_acc = winc && !w_full;
  assign w_rd_acc = rinc && !w_empty;
  assign w_ram_we = w_wr_acc && !rst;

  always_comb begin
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    if (w_wr_acc) begin
      w_wptr_nxt = r_wptr + PTR_W'(1);
    end
    if (w_rd_acc) begin
      w_rptr_nxt = r_rptr + PTR_W'(1);
    end
    if (winc && w_full) begin
      w_overflow_nxt = 1'b1;
    end
    if (rinc && w_empty) begin
      w_underflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  fifo_sync_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wptr[ADDR_SIZE-1:0]),
    .wdata (wdata),
    .raddr (r_rptr[ADDR_SIZE-1:0]),
    .rdata (w_ram_rdata)
  );

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_SIZE-1:0] r_rdata;
      logic                 r_rvalid;

      // Registered read: data lands with rvalid on the accepting edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) begin
            r_rdata <= w_ram_rdata;
          end
        end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
    end else begin : g_fwft
      // Head word is always presented; rinc only acknowledges it.
      assign rdata  = w_ram_rdata;
      assign rvalid = !w_empty;
    end
  endgenerate

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign count         = w_count;
  assign walmost_full  = (w_count >= AFULL_CNT);
  assign ralmost_empty = (w_count <= AEMPTY_CNT);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed scoreboard bench for fifo_sync in standard and FWFT read modes.
module tb_fifo_sync;

  logic        clk;
  logic        rst;
  logic        winc;
  logic [31:0] wdata;
  logic        wfull;
  logic        walmost_full;
  logic        overflow;
  logic        rinc;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rempty;
  logic        ralmost_empty;
  logic        underflow;
  logic [5:0]  count;

  logic        f_rst;
  logic        f_winc;
  logic [31:0] f_wdata;
  logic        f_wfull;
  logic        f_walmost_full;
  logic        f_overflow;
  logic        f_rinc;
  logic [31:0] f_rdata;
  logic        f_rvalid;
  logic        f_rempty;
  logic        f_ralmost_empty;
  logic        f_underflow;
  logic [5:0]  f_count;

  int          n_checks;
  int          n_errors;
  int          m_count;
  logic        m_ovf;
  logic        m_udf;
  logic [31:0] m_last;
  logic [31:0] sb[$];

  fifo_sync #(.FWFT(0)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .overflow      (overflow),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .underflow     (underflow),
    .count         (count)
  );

  fifo_sync #(.FWFT(1)) u_fwft (
    .clk           (clk),
    .rst           (f_rst),
    .winc          (f_winc),
    .wdata         (f_wdata),
    .wfull         (f_wfull),
    .walmost_full  (f_walmost_full),
    .overflow      (f_overflow),
    .rinc          (f_rinc),
    .rdata         (f_rdata),
    .rvalid        (f_rvalid),
    .rempty        (f_rempty),
    .ralmost_empty (f_ralmost_empty),
    .underflow     (f_underflow),
    .count         (f_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    chk("count", 32'(count), 32'(m_count));
    chk("rempty", 32'(rempty), 32'(m_count == 0));
    chk("wfull", 32'(wfull), 32'(m_count == 32));
    chk("walmost_full", 32'(walmost_full), 32'(m_count >= 28));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(m_count <= 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  // One clock of standard-mode traffic, scored against the reference queue.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    logic        w_ok;
    logic        r_ok;
    logic [31:0] exp_d;
    w_ok  = w && (m_count < 32);
    r_ok  = r && (m_count > 0);
    exp_d = m_last;
    if (w_ok) sb.push_back(d);
    winc  = w;
    wdata = d;
    rinc  = r;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    if (r_ok) exp_d = sb.pop_front();
    if (w && !w_ok) m_ovf = 1'b1;
    if (r && !r_ok) m_udf = 1'b1;
    m_count = m_count + int'(w_ok) - int'(r_ok);
    chk("rvalid", 32'(rvalid), 32'(r_ok));
    chk("rdata", rdata, exp_d);
    m_last = exp_d;
    check_status();
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst   = 1'b1;
    winc  = w;
    rinc  = r;
    wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    winc = 1'b0;
    rinc = 1'b0;
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_last  = 32'h0;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    check_status();
  endtask

  task automatic f_step(input logic w, input logic [31:0] d, input logic r);
    f_winc  = w;
    f_wdata = d;
    f_rinc  = r;
    @(posedge clk);
    #1;
    f_winc = 1'b0;
    f_rinc = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_count  = 0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_last   = 32'h0;
    rst      = 1'b1;
    winc     = 1'b0;
    rinc     = 1'b0;
    wdata    = 32'h0;
    f_rst    = 1'b1;
    f_winc   = 1'b0;
    f_rinc   = 1'b0;
    f_wdata  = 32'h0;

    do_reset(1'b0, 1'b0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 32; i++) cycle(1'b1, 32'(i), 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 32; i++) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    // Steady-state concurrent traffic at half occupancy across the pointer wrap.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1);

    // Concurrent request on empty, then on full.
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 32'h5A5A_0001, 1'b1);
    for (int i = 0; i < 31; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
    cycle(1'b1, 32'hBEEF, 1'b1);

    // Mid-stream reset with both requests high discards the contents.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0);
    do_reset(1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h777, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);

    // First-word-fall-through instance.
    @(posedge clk);
    #1;
    f_rst = 1'b0;
    chk("f_rst_rvalid", 32'(f_rvalid), 32'h0);
    chk("f_rst_rempty", 32'(f_rempty), 32'h1);
    chk("f_rst_count", 32'(f_count), 32'h0);
    chk("f_rst_wfull", 32'(f_wfull), 32'h0);
    chk("f_rst_walmost_full", 32'(f_walmost_full), 32'h0);
    chk("f_rst_ralmost_empty", 32'(f_ralmost_empty), 32'h1);
    chk("f_rst_overflow", 32'(f_overflow), 32'h0);
    chk("f_rst_underflow", 32'(f_underflow), 32'h0);
    f_step(1'b1, 32'hA5A5, 1'b0);
    chk("f_rdata_fall", f_rdata, 32'hA5A5);
    chk("f_rvalid_fall", 32'(f_rvalid), 32'h1);
    chk("f_count_one", 32'(f_count), 32'h1);
    f_step(1'b0, 32'h0, 1'b0);
    chk("f_rdata_hold", f_rdata, 32'hA5A5);
    f_step(1'b0, 32'h0, 1'b1);
    chk("f_rempty_ack", 32'(f_rempty), 32'h1);
    chk("f_rvalid_ack", 32'(f_rvalid), 32'h0);
    f_step(1'b1, 32'h11, 1'b0);
    f_step(1'b1, 32'h22, 1'b0);
    chk("f_rdata_head", f_rdata, 32'h11);
    f_step(1'b0, 32'h0, 1'b1);
    chk("f_rdata_next", f_rdata, 32'h22);
    chk("f_count_next", 32'(f_count), 32'h1);
    f_step(1'b0, 32'h0, 1'b1);
    f_step(1'b0, 32'h0, 1'b1);
    chk("f_underflow", 32'(f_underflow), 32'h1);
    chk("f_rempty_end", 32'(f_rempty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Single-clock, parametrised FIFO: the synchronous successor to the dual-port FIFO storage array. It adds pointer management, full/empty and programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It buffers command and data streams between vGPU pipeline stages that share one clock domain.

## Interface
- DATA_SIZE, 32, word width in bits
- ADDR_SIZE, 5, address width; DEPTH = 1<<ADDR_SIZE (32)
- AFULL_LVL, DEPTH-4 (28), walmost_full asserts when count >= AFULL_LVL
- AEMPTY_LVL, 4, ralmost_empty asserts when count <= AEMPTY_LVL
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- winc  in  1  write request
- wdata  in  DATA_SIZE  write data
- wfull  out  1  FIFO full
- walmost_full  out  1  count >= AFULL_LVL
- overflow  out  1  sticky: write attempted while full
- rinc  in  1  read request
- rdata  out  DATA_SIZE  read data
- rvalid  out  1  rdata holds a valid word
- rempty  out  1  FIFO empty
- ralmost_empty  out  1  count <= AEMPTY_LVL
- underflow  out  1  sticky: read attempted while empty
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH

## Operation
- Pointers wptr and rptr are ADDR_SIZE+1 bits wide. The low ADDR_SIZE bits address memory. The MSB is a wrap bit, and pointers wrap naturally modulo 2·DEPTH.
- Flags and count are derived from the pointers:
  - count = wptr - rptr, computed modulo 2^(ADDR_SIZE+1).
  - rempty = (wptr == rptr).
  - wfull = (MSBs differ and low bits equal).
- A write is accepted when winc && !wfull. On acceptance, mem[wptr] <= wdata and wptr increments. A rejected write leaves the pointer and memory unchanged and sets overflow.
- A read is accepted when rinc && !rempty. On acceptance, rptr increments. A rejected read sets underflow.
- Simultaneous winc and rinc are both evaluated against the current-cycle flags:
  - When full, the read is accepted, the write is rejected, and overflow is set.
  - When empty, the write is accepted, the read is rejected, and underflow is set.
  - Otherwise both are accepted and count is unchanged.
- overflow and underflow are cleared only by rst.
- Read behaviour with FWFT=0:
  - On an accepted read, rdata <= mem[rptr] and rvalid <= 1 on the same clock edge.
  - Otherwise rvalid <= 0 and rdata holds its previous value.
- Read behaviour with FWFT=1:
  - rdata = mem[rptr[ADDR_SIZE-1:0]] combinationally, and rvalid = !rempty.
  - rinc acknowledges the head word and advances to the next one.
- Reset values:
  - wptr = rptr = 0 and count = 0.
  - rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0.
  - overflow = underflow = 0.
  - With FWFT=0: rdata = 0 and rvalid = 0.
  - Memory contents are not reset.
- A reset asserted mid-stream discards all stored words in the same edge. Any winc/rinc sampled in that cycle is ignored.

## Timing
- Write-to-read latency: a word written at edge N is visible as non-empty after edge N.
  - With FWFT=0, rinc in cycle N+1 yields rdata/rvalid after edge N+1.
  - With FWFT=1, rdata is valid in cycle N+1 with no rinc required.
- All status outputs are combinational functions of the registered pointers and update one cycle after the accepted operation. There are no combinational paths from winc or rinc to any flag.
- overflow and underflow assert on the edge following the offending request.
- Throughput is one write plus one read per cycle, sustained.

## Structure
- The shared package vgpu_fifo_pkg holds:
  - the default DATA_SIZE and ADDR_SIZE;
  - the DEPTH calculation function;
  - the flag-threshold defaults.
- One sub-module, fifo_sync_ram, provides DEPTH × DATA_SIZE storage with a clocked write (enable gated by the accept condition) and an asynchronous read port.
- Pointer, flag and read-register logic live in fifo_sync.

## Test plan
- After reset, write 0..31 on consecutive cycles → wfull=1 and count=32 after the 32nd edge. walmost_full=1 from count 28. A 33rd write (0xDEAD) → overflow=1 and count stays 32.
- Drain the full FIFO with FWFT=0 → rdata sequence 0..31, each with rvalid=1 one edge after rinc. Then rempty=1 and ralmost_empty=1 at count<=4. A further rinc → underflow=1 and rvalid=0.
- At count=16, assert winc+rinc together for 40 cycles (pointers wrap past 32) → count stays 16 and data order is preserved across the wrap.
- Simultaneous winc+rinc when empty → write accepted, count=1, underflow=1. When full → read accepted, count=31, overflow=1.
- With FWFT=1, write 0xA5A5 into an empty FIFO → the next cycle shows rdata=0xA5A5 and rvalid=1 without rinc. rinc → rempty=1 on the next cycle.
- Assert rst at count=10, with winc and rinc both high → the next cycle shows count=0, rempty=1, overflow=underflow=0, rvalid=0, and the stale word is not readable.
